// File: rtl/rx_buf_pkg.sv
// Shared types for the RX buffer controller: reader states, packet descriptor,
// and the saturating-counter helper used when RX_BUF_CTRL_STATS_EN is defined.
package rx_buf_pkg;

   localparam int          DESC_ADDR_W = 9;
   localparam logic [15:0] STAT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ISSUE,
      RD_CAPTURE,
      RD_HOLD
   } rd_state_t;

   typedef struct packed {
      logic [DESC_ADDR_W-1:0] start_addr;
      logic [DESC_ADDR_W-1:0] end_addr;
   } desc_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == STAT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// Packet descriptor queue: DEPTH entries, pointers one bit wider than the index
// so full and empty are distinguished without a separate count.
module rx_desc_fifo
   import rx_buf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  push,
   input  desc_t push_desc,
   input  logic  pop,
   output desc_t head,
   output logic  full,
   output logic  empty
);

   localparam int IW = $clog2(DEPTH);

   logic [IW:0] wptr, rptr;
   desc_t       mem [DEPTH];

   assign empty = (wptr == rptr);
   assign full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
   assign head  = mem[rptr[IW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full)
            wptr <= wptr + 1'b1;
         if (pop && !empty)
            rptr <= rptr + 1'b1;
      end
   end

   // Storage needs no reset; entries are only read once the pointers say valid.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wptr[IW-1:0]] <= push_desc;
   end

endmodule

// File: rtl/rx_buf_ctrl.sv
// RX payload RAM controller: write pass-through, packet boundary tracking,
// descriptor queue and stream read-out. Statistics counters exist only when
// RX_BUF_CTRL_STATS_EN is defined; otherwise they read as zero.
module rx_buf_ctrl
   import rx_buf_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8,
   parameter int DESC_DEPTH = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  wr_en_in,
   input  logic [ADDR_WIDTH-1:0] wr_addr_in,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  desc_full,
   output logic [15:0]           stat_pkt_cnt,
   output logic [15:0]           stat_drop_cnt
);

   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] start_q, last_q;
   logic                  push, pop, full, empty;
   desc_t                 push_desc, head;
   rd_state_t             state;
   logic [ADDR_WIDTH-1:0] rd_addr, end_addr;

   // Boundary tracker: envelope of wr_en_in delimits one packet.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_en_q <= 1'b0;
         start_q <= '0;
         last_q  <= '0;
      end else begin
         wr_en_q <= wr_en_in;
         if (wr_en_in && !wr_en_q)
            start_q <= wr_addr_in;
         if (wr_en_in)
            last_q <= wr_addr_in;
      end
   end

   assign push      = wr_en_q && !wr_en_in;
   assign push_desc = '{start_addr: start_q, end_addr: last_q};
   assign pop       = (state == RD_HOLD) && m_valid && m_ready && m_last;
   assign desc_full = full;

   rx_desc_fifo #(
      .DEPTH (DESC_DEPTH)
   ) u_desc_fifo (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .push      (push),
      .push_desc (push_desc),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   // Writer always owns the port; the reader only borrows idle cycles.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = rd_addr;
      ram_wdata = '0;
      if (wr_en_in) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_addr_in;
         ram_wdata = wr_data_in;
      end else if (state == RD_ISSUE) begin
         ram_en    = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= RD_IDLE;
         rd_addr  <= '0;
         end_addr <= '0;
         m_data   <= '0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
      end else begin
         case (state)
            RD_IDLE: begin
               if (!empty) begin
                  rd_addr  <= head.start_addr;
                  end_addr <= head.end_addr;
                  state    <= RD_ISSUE;
               end
            end
            RD_ISSUE: begin
               if (!wr_en_in)
                  state <= RD_CAPTURE;
            end
            RD_CAPTURE: begin
               m_data  <= ram_rdata;
               m_valid <= 1'b1;
               m_last  <= (rd_addr == end_addr);
               state   <= RD_HOLD;
            end
            RD_HOLD: begin
               if (m_valid && m_ready) begin
                  m_valid <= 1'b0;
                  if (m_last) begin
                     state <= RD_IDLE;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                     state   <= RD_ISSUE;
                  end
               end
            end
            default: state <= RD_IDLE;
         endcase
      end
   end

`ifdef RX_BUF_CTRL_STATS_EN
   logic [15:0] pkt_cnt, drop_cnt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pkt_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         if (pop)
            pkt_cnt <= sat_inc(pkt_cnt);
         if (push && full)
            drop_cnt <= sat_inc(drop_cnt);
      end
   end

   assign stat_pkt_cnt  = pkt_cnt;
   assign stat_drop_cnt = drop_cnt;
`else
   assign stat_pkt_cnt  = 16'h0000;
   assign stat_drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_buf_ctrl.sv
// Directed bench for rx_buf_ctrl with a behavioural single-port RAM; statistics
// expectations follow RX_BUF_CTRL_STATS_EN.
module tb_rx_buf_ctrl;

`ifdef RX_BUF_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [8:0]  wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        ram_en, ram_we;
   logic [8:0]  ram_addr;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;
   logic [7:0]  m_data;
   logic        m_valid, m_last;
   logic        m_ready = 1'b0;
   logic        desc_full;
   logic [15:0] stat_pkt_cnt, stat_drop_cnt;

   rx_buf_ctrl #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .DESC_DEPTH(4)) dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .wr_en_in      (wr_en),
      .wr_addr_in    (wr_addr),
      .wr_data_in    (wr_data),
      .ram_en        (ram_en),
      .ram_we        (ram_we),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_rdata     (ram_rdata),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_last        (m_last),
      .m_ready       (m_ready),
      .desc_full     (desc_full),
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_drop_cnt (stat_drop_cnt)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [512];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   int n_chk = 0, n_err = 0;
   int cyc_n = 0, first_v = -1, fall_cyc = 0;
   int hold_err = 0, wport_err = 0;
   logic [7:0] got_d [$];
   logic       got_l [$];
   logic [8:0] rd_q  [$];
   logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
   logic [7:0] pd = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] st(input int v);
      return STATS ? 16'(v) : 16'h0000;
   endfunction

   // Inputs are set at the falling edge; sample 1ns later, then wait for the next falling edge.
   task automatic cyc();
      #1;
      if (m_valid && first_v < 0) first_v = cyc_n;
      if (pv && !pr && rst_n && (!m_valid || m_data !== pd || m_last !== pl)) hold_err++;
      if (m_valid && m_ready) begin
         got_d.push_back(m_data);
         got_l.push_back(m_last);
      end
      if (wr_en && !(ram_en && ram_we && ram_addr == wr_addr && ram_wdata == wr_data)) wport_err++;
      if (ram_en && !ram_we) rd_q.push_back(ram_addr);
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic clear_q();
      got_d.delete(); got_l.delete(); rd_q.delete();
   endtask

   task automatic write_pkt(input logic [8:0] start, input int len, input logic [7:0] base);
      for (int i = 0; i < len; i++) begin
         wr_en = 1'b1; wr_addr = start + 9'(i); wr_data = base + 8'(i);
         cyc();
      end
      wr_en = 1'b0;
      fall_cyc = cyc_n;
      cyc();
   endtask

   task automatic wait_bytes(input int n, input bit toggle, input int budget);
      int k = 0;
      while (got_d.size() < n && k < budget) begin
         if (toggle) m_ready = ~m_ready;
         cyc();
         k++;
      end
      if (got_d.size() < n) chk("timeout_bytes", got_d.size(), n);
   endtask

   task automatic check_pkt(input string tag, input int off, input int len, input logic [7:0] base);
      int mism = 0;
      for (int i = 0; i < len; i++) begin
         if (off + i >= got_d.size()) mism++;
         else if (got_d[off+i] !== base + 8'(i) || got_l[off+i] !== (i == len - 1)) mism++;
      end
      chk(tag, mism, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int mism;
      @(negedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_desc_full", desc_full, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_pkt_cnt", stat_pkt_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single packet, latency from falling envelope to first valid
      clear_q(); m_ready = 1'b1; first_v = -1;
      write_pkt(9'd0, 8, 8'h10);
      wait_bytes(8, 1'b0, 200);
      repeat (4) cyc();
      chk("t1_nbytes", got_d.size(), 8);
      check_pkt("t1_stream", 0, 8, 8'h10);
      chk("t1_latency", first_v - fall_cyc, 4);
      chk("t1_pkt_cnt", stat_pkt_cnt, st(1));

      // Second packet written while the first is streaming
      clear_q(); wport_err = 0;
      write_pkt(9'd16, 8, 8'h20);
      wait_bytes(2, 1'b0, 100);
      write_pkt(9'd24, 8, 8'h30);
      wait_bytes(16, 1'b0, 400);
      chk("t2_nbytes", got_d.size(), 16);
      check_pkt("t2_pkt_a", 0, 8, 8'h20);
      check_pkt("t2_pkt_b", 8, 8, 8'h30);
      chk("t2_write_port", wport_err, 0);
      chk("t2_pkt_cnt", stat_pkt_cnt, st(3));

      // Packet straddling the top of the address space
      clear_q();
      write_pkt(9'd508, 8, 8'h40);
      wait_bytes(8, 1'b0, 200);
      chk("t3_nreads", rd_q.size(), 8);
      mism = 0;
      for (int i = 0; i < 8; i++)
         if (i >= rd_q.size() || rd_q[i] !== 9'd508 + 9'(i)) mism++;
      chk("t3_read_addrs", mism, 0);
      check_pkt("t3_stream", 0, 8, 8'h40);

      // Queue overflow with a stalled consumer
      clear_q(); m_ready = 1'b0;
      for (int p = 0; p < 5; p++) begin
         write_pkt(9'd32 + 9'(8*p), 8, 8'h50 + 8'(8*p));
         if (p == 2) chk("t4_full_after3", desc_full, 0);
         if (p == 3) chk("t4_full_after4", desc_full, 1);
      end
      chk("t4_drop_cnt", stat_drop_cnt, st(1));
      m_ready = 1'b1;
      wait_bytes(32, 1'b0, 600);
      repeat (10) cyc();
      chk("t4_nbytes", got_d.size(), 32);
      for (int p = 0; p < 4; p++)
         check_pkt($sformatf("t4_pkt%0d", p), 8*p, 8, 8'h50 + 8'(8*p));
      chk("t4_full_drained", desc_full, 0);
      chk("t4_pkt_cnt", stat_pkt_cnt, st(8));

      // Consumer ready toggling every cycle
      clear_q(); m_ready = 1'b0;
      write_pkt(9'd80, 6, 8'h90);
      wait_bytes(6, 1'b1, 300);
      m_ready = 1'b1;
      repeat (6) cyc();
      chk("t5_nbytes", got_d.size(), 6);
      check_pkt("t5_stream", 0, 6, 8'h90);
      chk("t5_hold_stable", hold_err, 0);

      // Reset while a byte is presented mid-packet
      clear_q(); m_ready = 1'b0;
      write_pkt(9'd100, 8, 8'hA0);
      for (int k = 0; k < 50 && !m_valid; k++) cyc();
      chk("t6_valid_seen", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_m_valid", m_valid, 0);
      chk("t6_rst_m_last", m_last, 0);
      chk("t6_rst_m_data", m_data, 0);
      chk("t6_rst_ram_en", ram_en, 0);
      chk("t6_rst_pkt_cnt", stat_pkt_cnt, 0);
      chk("t6_rst_drop_cnt", stat_drop_cnt, 0);
      cyc();
      rst_n = 1'b1; m_ready = 1'b1;
      clear_q();
      repeat (10) cyc();
      chk("t6_queue_empty", got_d.size() + rd_q.size(), 0);
      write_pkt(9'd120, 5, 8'hC0);
      wait_bytes(5, 1'b0, 200);
      check_pkt("t6_stream", 0, 5, 8'hC0);
      chk("t6_pkt_cnt", stat_pkt_cnt, st(1));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
